register_read_arbiter: RTL and testbench
========================================

Name: register_read_arbiter

Overview:
- Shares the single read port of the 16 x 16-bit register file, and its 4-bit select mux, among NUM_REQ requesters.
- Requesters include decode operand fetch, debug/scan, and the interrupt save unit.
- Uses round-robin arbitration and a two-stage pipeline: grant plus mux-select drive, then data capture with requester tag.
- Sits between the requesters and the register-file read mux in the single-cycle core's register block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, register width
ADDR_W, 4, register index width (16 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester read request, level
addr  in  NUM_REQ*ADDR_W  per-requester register index; requester i uses bits [i*ADDR_W +: ADDR_W]
gnt  out  NUM_REQ  one-hot grant pulse, registered
rf_sel  out  ADDR_W  select driven to the register-file read mux, registered
rf_data  in  DATA_W  combinational read-mux output for rf_sel
rdata  out  DATA_W  captured read data
rdata_valid  out  1  one-cycle pulse, rdata/rdata_id valid
rdata_id  out  $clog2(NUM_REQ)  index of requester owning rdata

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately clears all state.
  - gnt=0, rf_sel=0, rdata=0, rdata_valid=0, rdata_id=0, rr pointer=0.
  - An in-flight read is dropped; no rdata_valid is produced for it after reset release.
- Stage A, arbitration, evaluated each cycle:
  - eligible = req & ~gnt. A requester granted last cycle is masked for one cycle.
  - Pick the first eligible index searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - On a pick k, at the clock edge: gnt=onehot(k), rf_sel=addr[k], id_a=k, vld_a=1, ptr=(k+1) mod NUM_REQ.
  - With no eligible requester: gnt=0, vld_a=0; ptr and rf_sel hold.
- Stage B, capture: if vld_a then rdata=rf_data, rdata_id=id_a, rdata_valid=1; else rdata_valid=0 and rdata/rdata_id hold.
- Latency:
  - req seen at edge N gives gnt high in cycle N+1.
  - rdata_valid is high in cycle N+2.
- Throughput:
  - One grant per cycle aggregate.
  - Max one grant per two cycles per requester, due to the mask.
- Handshake rules:
  - Requester holds req and addr stable until it sees gnt.
  - It may drop req, or present a new addr, in the gnt cycle.
  - addr is sampled only at the granting edge.
  - Dropping req before grant withdraws the request with no side effects.
- Boundaries:
  - A single requester asserting continuously is granted every other cycle.
  - With all requesters asserting, grants follow 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 grants.
  - ptr wraps from NUM_REQ-1 to 0.
  - rf_sel changes only on a grant, so the mux output is stable for stage B.

Optional Feature:
REG_READ_ARB_STATS_EN
- Defined:
  - Adds ports stat_sel (in, $clog2(NUM_REQ)) and stat_count (out, 16).
  - Adds one 16-bit grant counter per requester, incremented on each grant and saturating at 16'hFFFF.
  - stat_count = counter[stat_sel], combinational read.
  - Counters clear on rst_n low.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package reg_file_pkg:
  - REG_DATA_W=16, REG_ADDR_W=4, REG_COUNT=16
  - reg_idx_t, reg_word_t typedefs
  - STAT_W=16
- One natural sub-module, rr_pick:
  - Combinational round-robin picker.
  - Inputs: eligible vector, ptr.
  - Outputs: found, one-hot, index.
  - Instantiated once in stage A.

Test Plan:
1. Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, rdata_valid=0, rf_sel=0. Release rst_n -> first gnt=4'b0001 one cycle later.
2. Single read: req[2]=1, addr[2]=4'd9, register 9 = 16'hBEEF -> gnt=4'b0100 at N+1, rf_sel=9; rdata_valid=1, rdata=16'hBEEF, rdata_id=2 at N+2.
3. Full contention: req=4'b1111 held, distinct addrs -> gnt sequence 0001,0010,0100,1000,0001, one per cycle; rdata_id sequence 0,1,2,3,0 two cycles later.
4. Solo continuous: only req[1]=1 for 6 cycles -> gnt[1] high on alternate cycles (3 grants); 3 rdata_valid pulses.
5. Mid-operation reset: assert rst_n=0 in the cycle gnt is high -> no rdata_valid follows; ptr=0 after release.
6. With REG_READ_ARB_STATS_EN: 5 grants to requester 3, then stat_sel=3 -> stat_count=5. Preload the counter near saturation -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared register-file geometry, word/index types and the
//               saturating increment used by the grant statistics.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 4;
    localparam int REG_COUNT  = 16;
    localparam int STAT_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : register_read_arbiter_if
// Description : Requester / register-file side bundle of the read arbiter.
//               slave = arbiter view, master = requesters + register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rf_sel;
    logic [DATA_W-1:0]         rf_data;
    logic [DATA_W-1:0]         rdata;
    logic                      rdata_valid;
    logic [ID_W-1:0]           rdata_id;

    modport slave (
        input  req, addr, rf_data,
        output gnt, rf_sel, rdata, rdata_valid, rdata_id
    );

    modport master (
        output req, addr, rf_data,
        input  gnt, rf_sel, rdata, rdata_valid, rdata_id
    );

endinterface
`default_nettype wire

// File: rtl/register_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : register_read_arbiter_rr_pick
// Description : Combinational round-robin picker: first set bit of i_eligible
//               searching from i_ptr upward, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module register_read_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_eligible,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic                    o_found,
    output logic [NUM_REQ-1:0]      o_onehot,
    output logic [ID_W-1:0]         o_idx
);

    always_comb begin
        int         w_sum;
        logic [ID_W-1:0] w_k;
        o_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_sum    = 0;
        w_k      = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = int'(i_ptr) + off;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_k = ID_W'(w_sum);
            if (i_eligible[w_k]) begin
                o_found       = 1'b1;
                o_onehot      = '0;
                o_onehot[w_k] = 1'b1;
                o_idx         = w_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_read_arbiter
// Description : Round-robin arbiter for the shared register-file read port.
//               Stage A grants and drives rf_sel, stage B captures rf_data.
//               Optional per-requester grant counters: REG_READ_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module register_read_arbiter
    import reg_file_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    register_read_arbiter_if.slave          bus
`ifdef REG_READ_ARB_STATS_EN
    ,
    input  wire logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [STAT_W-1:0]               stat_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ADDR_W-1:0]  w_pick_addr;
    logic [ID_W-1:0]    w_ptr_next;

    logic [NUM_REQ-1:0] r_gnt;
    logic [ADDR_W-1:0]  r_rf_sel;
    logic [ID_W-1:0]    r_id_a;
    logic               r_vld_a;
    logic [ID_W-1:0]    r_ptr;
    logic [DATA_W-1:0]  r_rdata;
    logic [ID_W-1:0]    r_rdata_id;
    logic               r_rdata_valid;

    // Last cycle's grantee sits out one cycle so it can drop or update its request.
    assign w_eligible = bus.req & ~r_gnt;

    register_read_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_found    (w_found),
        .o_onehot   (w_onehot),
        .o_idx      (w_pick)
    );

    always_comb begin
        w_pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_pick_addr = bus.addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_ptr_next = (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= '0;
            r_rf_sel <= '0;
            r_id_a   <= '0;
            r_vld_a  <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_gnt   <= w_onehot;
            r_vld_a <= w_found;
            if (w_found) begin
                r_rf_sel <= w_pick_addr;
                r_id_a   <= w_pick;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata       <= '0;
            r_rdata_id    <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= r_vld_a;
            if (r_vld_a) begin
                r_rdata    <= bus.rf_data;
                r_rdata_id <= r_id_a;
            end
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rf_sel      = r_rf_sel;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.rdata_id    = r_rdata_id;

`ifdef REG_READ_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_onehot[i]) begin
                    r_stat_cnt[i] <= sat_inc(r_stat_cnt[i]);
                end
            end
        end
    end

    assign stat_count = r_stat_cnt[stat_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_read_arbiter
// Description : Directed self-checking bench for register_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_read_arbiter;
    import reg_file_pkg::*;

    localparam int NUM_REQ = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_gnt;
    int   n_vld;
    reg_word_t regs [REG_COUNT];

    register_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) bus ();

`ifdef REG_READ_ARB_STATS_EN
    logic [1:0]        stat_sel;
    logic [STAT_W-1:0] stat_count;
`endif

    register_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (REG_DATA_W),
        .ADDR_W  (REG_ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef REG_READ_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    assign bus.rf_data = regs[bus.rf_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic reg_word_t reg_val(input int i);
        return (i == 9) ? 16'hBEEF : reg_word_t'(16'h1111 * i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g [5];
        logic [1:0] exp_id [5];
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        n_vec  = 0;
        n_err  = 0;
        for (int i = 0; i < REG_COUNT; i++) regs[i] = reg_val(i);
`ifdef REG_READ_ARB_STATS_EN
        stat_sel = 2'd0;
`endif

        // Reset held with every requester asserting
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.addr = {4'd12, 4'd9, 4'd5, 4'd3};
        tick();
        tick();
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_vld", bus.rdata_valid, 1'b0);
        chk("rst_sel", bus.rf_sel, 4'd0);
        chk("rst_rdata", bus.rdata, 16'h0000);
        chk("rst_id", bus.rdata_id, 2'd0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", bus.gnt, 4'b0001);
        chk("first_sel", bus.rf_sel, 4'd3);
        bus.req = 4'b0000;
        tick();
        chk("first_vld", bus.rdata_valid, 1'b1);
        chk("first_rdata", bus.rdata, reg_val(3));
        chk("first_id", bus.rdata_id, 2'd0);

        // Single read of register 9 by requester 2
        bus.req = 4'b0100;
        tick();
        chk("single_gnt", bus.gnt, 4'b0100);
        chk("single_sel", bus.rf_sel, 4'd9);
        chk("single_vld0", bus.rdata_valid, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("single_vld", bus.rdata_valid, 1'b1);
        chk("single_rdata", bus.rdata, 16'hBEEF);
        chk("single_id", bus.rdata_id, 2'd2);
        chk("single_gnt_off", bus.gnt, 4'b0000);
        tick();
        chk("sel_hold", bus.rf_sel, 4'd9);
        chk("vld_pulse", bus.rdata_valid, 1'b0);

        // Full contention from a fresh pointer
        rst_n = 1'b0;
        #2;
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("full_gnt%0d", i), bus.gnt, exp_g[i]);
            if (i >= 1) begin
                chk($sformatf("full_vld%0d", i), bus.rdata_valid, 1'b1);
                chk($sformatf("full_id%0d", i), bus.rdata_id, exp_id[i-1]);
                chk($sformatf("full_rdata%0d", i), bus.rdata,
                    reg_val(int'(bus.addr[int'(exp_id[i-1])*4 +: 4])));
            end
        end
        bus.req = 4'b0000;
        tick();
        chk("full_last_id", bus.rdata_id, 2'd0);
        chk("full_last_rdata", bus.rdata, reg_val(3));

        // One requester asserting continuously is granted every other cycle
        n_gnt   = 0;
        n_vld   = 0;
        bus.req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("solo_gnt%0d", i), bus.gnt, (i % 2 == 0) ? 4'b0010 : 4'b0000);
            if (bus.gnt[1]) n_gnt++;
            if (bus.rdata_valid) begin
                n_vld++;
                chk($sformatf("solo_id%0d", i), bus.rdata_id, 2'd1);
            end
        end
        bus.req = 4'b0000;
        chk("solo_gnt_count", n_gnt, 3);
        chk("solo_vld_count", n_vld, 3);

        // Reset during a grant cycle drops the in-flight read
        bus.req = 4'b0001;
        tick();
        chk("mid_gnt", bus.gnt, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt_clr", bus.gnt, 4'b0000);
        chk("mid_vld_clr", bus.rdata_valid, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("mid_vld_rst", bus.rdata_valid, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("mid_ptr0_gnt", bus.gnt, 4'b0001);
        chk("mid_no_vld", bus.rdata_valid, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("mid_new_vld", bus.rdata_valid, 1'b1);
        chk("mid_new_id", bus.rdata_id, 2'd0);

`ifdef REG_READ_ARB_STATS_EN
        bus.req = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        bus.req = 4'b0000;
        tick();
        stat_sel = 2'd3;
        #1;
        chk("stat3", stat_count, 16'd5);
        stat_sel = 2'd0;
        #1;
        chk("stat0", stat_count, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
